// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and command definitions for the ALU operand driver
package alu_pkg;

  localparam int DW = 8;

  typedef enum logic [2:0] {
    OP_NOT = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } drv_state_e;

  typedef struct packed {
    opcode_e       op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  // Division and modulo by zero are trapped here and never reach the ALU.
  function automatic logic is_div_zero(cmd_t c);
    return ((c.op == OP_DIV) || (c.op == OP_MOD)) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n,
  input  cmd_t                       wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output cmd_t                       rd_data,
  output logic                       rd_valid,
  input  logic                       rd_en,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full refuses a push even if a pop frees a slot in the same cycle.
  assign wr_ready = (count != CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_en & rd_valid;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// rtl/alu_op_driver.sv - buffers {op,A,B} commands and issues them to the ALU on three channels
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int DATA_IN_WIDTH = DW,
  parameter int CMD_DEPTH     = 4
) (
  input  logic                           clk_i,
  input  logic                           arst_n,
  input  logic [DATA_IN_WIDTH-1:0]       cmd_a,
  input  logic [DATA_IN_WIDTH-1:0]       cmd_b,
  input  logic [2:0]                     cmd_op,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  output logic [DATA_IN_WIDTH-1:0]       alu_a,
  output logic                           alu_a_valid,
  input  logic                           alu_a_ready,
  output logic [DATA_IN_WIDTH-1:0]       alu_b,
  output logic                           alu_b_valid,
  input  logic                           alu_b_ready,
  output logic [2:0]                     alu_op,
  output logic                           alu_op_valid,
  input  logic                           alu_op_ready,
  input  logic [DATA_IN_WIDTH:0]         alu_out,
  input  logic                           alu_out_valid,
  output logic                           alu_out_ready,
  output logic [DATA_IN_WIDTH:0]         res_data,
  output logic                           res_err,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
  output logic                           busy
);

  drv_state_e state, state_n;
  cmd_t       cmd_in;
  cmd_t       head;
  cmd_t       iss;
  logic       head_valid;
  logic       pop;
  logic       a_done, b_done, op_done, out_done;
  logic       all_done;

  assign cmd_in = '{op: opcode_e'(cmd_op), a: cmd_a, b: cmd_b};

  alu_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n   (arst_n),
    .wr_data  (cmd_in),
    .wr_valid (cmd_valid),
    .wr_ready (cmd_ready),
    .rd_data  (head),
    .rd_valid (head_valid),
    .rd_en    (pop),
    .count    (cmd_count)
  );

  assign alu_a  = iss.a;
  assign alu_b  = iss.b;
  assign alu_op = iss.op;
  assign busy   = (state != IDLE) | head_valid;

  // In ISSUE each valid is ~done, so "done or handshaking now" reduces to done | ready.
  assign all_done = (a_done | alu_a_ready) & (b_done | alu_b_ready) &
                    (op_done | alu_op_ready) & (out_done | alu_out_valid);

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n       = state;
    pop           = 1'b0;
    alu_a_valid   = 1'b0;
    alu_b_valid   = 1'b0;
    alu_op_valid  = 1'b0;
    alu_out_ready = 1'b0;
    res_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (head_valid) begin
          pop     = 1'b1;
          state_n = is_div_zero(head) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        alu_a_valid   = ~a_done;
        alu_b_valid   = ~b_done;
        alu_op_valid  = ~op_done;
        alu_out_ready = ~out_done;
        if (all_done) state_n = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      iss      <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      op_done  <= 1'b0;
      out_done <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (state == IDLE && head_valid) begin
      iss <= head;
      if (is_div_zero(head)) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end else begin
        a_done   <= 1'b0;
        b_done   <= 1'b0;
        op_done  <= 1'b0;
        out_done <= 1'b0;
      end
    end else if (state == ISSUE) begin
      if (alu_a_valid & alu_a_ready)   a_done  <= 1'b1;
      if (alu_b_valid & alu_b_ready)   b_done  <= 1'b1;
      if (alu_op_valid & alu_op_ready) op_done <= 1'b1;
      if (alu_out_valid & alu_out_ready) begin
        out_done <= 1'b1;
        res_data <= alu_out;
        res_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// tb/tb_alu_op_driver.sv - directed self-checking bench for alu_op_driver
module tb_alu_op_driver;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       arst_n;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_valid, cmd_ready;
  logic [7:0] alu_a, alu_b;
  logic       alu_a_valid, alu_a_ready, alu_b_valid, alu_b_ready;
  logic [2:0] alu_op;
  logic       alu_op_valid, alu_op_ready;
  logic [8:0] alu_out;
  logic       alu_out_valid, alu_out_ready;
  logic [8:0] res_data;
  logic       res_err, res_valid, res_ready;
  logic [2:0] cmd_count;
  logic       busy;
  logic       corrupt;
  logic [8:0] model;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_driver #(.DATA_IN_WIDTH(8), .CMD_DEPTH(4)) dut (
    .clk_i(clk_i), .arst_n(arst_n),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .alu_a(alu_a), .alu_a_valid(alu_a_valid), .alu_a_ready(alu_a_ready),
    .alu_b(alu_b), .alu_b_valid(alu_b_valid), .alu_b_ready(alu_b_ready),
    .alu_op(alu_op), .alu_op_valid(alu_op_valid), .alu_op_ready(alu_op_ready),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .alu_out_ready(alu_out_ready),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
    .cmd_count(cmd_count), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU answering on the same cycle; corrupt garbles it after capture.
  always_comb begin
    model = '0;
    case (alu_op)
      3'd0: model = {1'b0, ~alu_a};
      3'd1: model = {1'b0, alu_a} + {1'b0, alu_b};
      3'd2: model = {1'b0, alu_a} - {1'b0, alu_b};
      3'd3: model = (alu_b == 0) ? 9'd0 : {1'b0, alu_a / alu_b};
      3'd4: model = (alu_b == 0) ? 9'd0 : {1'b0, alu_a % alu_b};
      3'd5: model = {1'b0, alu_a & alu_b};
      3'd6: model = {1'b0, alu_a | alu_b};
      default: model = {1'b0, alu_a ^ alu_b};
    endcase
    alu_out = model ^ {9{corrupt}};
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
  endtask

  task automatic wait_res(input string tag, input logic [8:0] d, input logic e);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, d);
    check({tag, "_err"}, res_err, e);
    step();
  endtask

  initial begin
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    alu_a_ready = 1'b0; alu_b_ready = 1'b0; alu_op_ready = 1'b0;
    alu_out_valid = 1'b0; res_ready = 1'b0; corrupt = 1'b0;
    #3;
    check("rst_valids", {alu_a_valid, alu_b_valid, alu_op_valid, res_valid}, 0);
    check("rst_out_ready", alu_out_ready, 0);
    check("rst_res", {res_err, res_data}, 0);
    check("rst_count", cmd_count, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    #10 arst_n = 1'b1;
    step();

    // ADD FF+01, everything ready
    alu_a_ready = 1; alu_b_ready = 1; alu_op_ready = 1; alu_out_valid = 1; res_ready = 1;
    set_cmd(OP_ADD, 8'hFF, 8'h01);
    step();
    cmd_valid = 0;
    check("add_count", cmd_count, 1);
    check("add_op_valid_k", alu_op_valid, 0);
    step();
    check("add_op_valid_k1", alu_op_valid, 1);
    check("add_alu_a", alu_a, 8'hFF);
    check("add_out_ready", alu_out_ready, 1);
    step();
    check("add_res_valid", res_valid, 1);
    check("add_res_data", res_data, 9'h100);
    check("add_res_err", res_err, 0);
    step();
    check("add_idle_valid", res_valid, 0);
    check("add_idle_busy", busy, 0);

    // DIV by zero trapped, then MOD 7,2
    set_cmd(OP_DIV, 8'd9, 8'd0);
    step();
    cmd_valid = 0;
    check("dz_no_alu_k", {alu_a_valid, alu_b_valid, alu_op_valid}, 0);
    step();
    check("dz_res_valid", res_valid, 1);
    check("dz_res", {res_err, res_data}, 10'h200);
    check("dz_no_alu", {alu_a_valid, alu_b_valid, alu_op_valid, alu_out_ready}, 0);
    step();
    set_cmd(OP_MOD, 8'd7, 8'd2);
    step();
    cmd_valid = 0;
    step();
    step();
    check("mod_res_valid", res_valid, 1);
    check("mod_res_data", res_data, 9'd1);
    check("mod_res_err", res_err, 0);
    step();

    // Fill FIFO while downstream stalls
    res_ready = 0;
    set_cmd(OP_ADD, 8'd1, 8'd2);    step();
    set_cmd(OP_SUB, 8'd10, 8'd4);   step();
    set_cmd(OP_AND, 8'hF0, 8'h3C);  step();
    set_cmd(OP_OR, 8'h0F, 8'h30);   step();
    set_cmd(OP_XOR, 8'hFF, 8'h0F);  step();
    check("full_cmd_ready", cmd_ready, 0);
    check("full_count", cmd_count, 4);
    set_cmd(OP_ADD, 8'h55, 8'h55);
    step(); step();
    check("full_refused", cmd_count, 4);
    check("full_still_ready0", cmd_ready, 0);
    cmd_valid = 0;
    res_ready = 1;
    wait_res("ord0", 9'h003, 0);
    wait_res("ord1", 9'h006, 0);
    wait_res("ord2", 9'h030, 0);
    wait_res("ord3", 9'h03F, 0);
    wait_res("ord4", 9'h0F0, 0);
    check("drain_busy", busy, 0);

    // Operand A stalled three cycles
    alu_a_ready = 0;
    set_cmd(OP_ADD, 8'h20, 8'h11);
    step();
    cmd_valid = 0;
    step();
    check("stall_first", {alu_a_valid, alu_b_valid, alu_op_valid, alu_out_ready}, 4'hF);
    step();
    check("stall_bo_drop", {alu_b_valid, alu_op_valid, alu_out_ready}, 0);
    check("stall_a_held", alu_a_valid, 1);
    check("stall_a_data", alu_a, 8'h20);
    corrupt = 1;
    step();
    check("stall_a_held2", alu_a_valid, 1);
    check("stall_a_data2", alu_a, 8'h20);
    check("stall_no_res", res_valid, 0);
    alu_a_ready = 1;
    step();
    check("stall_res_valid", res_valid, 1);
    check("stall_res_once", res_data, 9'h031);
    corrupt = 0;
    step();

    // Push during pop at count=2, pointers already wrapped
    res_ready = 0;
    set_cmd(OP_XOR, 8'hAA, 8'h55); step();
    set_cmd(OP_SUB, 8'd5, 8'd3);   step();
    set_cmd(OP_OR, 8'd1, 8'd2);    step();
    cmd_valid = 0;
    check("pp_count_pre", cmd_count, 2);
    check("pp_x_data", res_data, 9'h0FF);
    res_ready = 1;
    step();
    res_ready = 0;
    set_cmd(OP_ADD, 8'd3, 8'd4);
    step();
    cmd_valid = 0;
    check("pp_count_same", cmd_count, 2);
    res_ready = 1;
    wait_res("wrap_sub", 9'd2, 0);
    wait_res("wrap_or", 9'd3, 0);
    wait_res("wrap_add", 9'd7, 0);

    // Reset while ISSUE waits on operand A, with a command still buffered
    alu_a_ready = 0;
    set_cmd(OP_OR, 8'd1, 8'd2);   step();
    set_cmd(OP_AND, 8'd3, 8'd1);  step();
    cmd_valid = 0;
    step();
    check("mid_a_valid", alu_a_valid, 1);
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_valids", {alu_a_valid, alu_b_valid, alu_op_valid, res_valid, alu_out_ready}, 0);
    check("mid_rst_count", cmd_count, 0);
    #3 arst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_count", cmd_count, 0);
    check("post_rst_res", {res_err, res_data}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
